// File: rtl/weight_ctrl_pkg.sv
// Shared defaults and state encoding for the weight-RAM bank controller.
package weight_ctrl_pkg;

  localparam int unsigned K_DEF      = 5;
  localparam int unsigned NCH_DEF    = 3;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_LOADED = 2'd2,
    ST_READ   = 2'd3
  } state_t;

endpackage

// File: rtl/kernel_idx_counter.sv
// Row/column index counter: clear, increment, wrap col COLS-1 -> 0 with row+1, last-position flag.
module kernel_idx_counter #(
  parameter int unsigned ROWS = 5,
  parameter int unsigned COLS = 5,
  parameter int unsigned W    = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] row,
  output logic [W-1:0] col,
  output logic         last
);

  localparam logic [W-1:0] ROW_MAX = W'(ROWS - 1);
  localparam logic [W-1:0] COL_MAX = W'(COLS - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (inc) begin
      if (col == COL_MAX) begin
        col <= '0;
        row <= (row == ROW_MAX) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign last = (row == ROW_MAX) && (col == COL_MAX);

endmodule

// File: rtl/weight_ram_ctrl.sv
// Loads a streamed NCH-channel KxK kernel into the weight RAM bank row-major, then replays its
// rows on request with row_valid aligned to RAM read data.
module weight_ram_ctrl
  import weight_ctrl_pkg::*;
#(
  parameter int unsigned K      = K_DEF,
  parameter int unsigned NCH    = NCH_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_start,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [NCH*DATA_W-1:0] w_data,
  output logic                  load_done,
  input  logic                  rd_start,
  output logic                  rd_busy,
  output logic                  row_valid,
  output logic [ADDR_W-1:0]     row_idx,
  output logic                  rd_last,
  output logic                  cmd_err,
  output logic [ADDR_W-1:0]     ram_addr_write,
  output logic [K-1:0]          ram_write_enable,
  output logic [NCH*DATA_W-1:0] ram_data_in,
  output logic [ADDR_W-1:0]     ram_addr_read,
  output logic                  ram_read_enable
);

  state_t state, state_nxt;

  logic                  w_ready_nxt, load_done_nxt, cmd_err_nxt, rd_busy_nxt;
  logic [ADDR_W-1:0]     waddr_nxt, raddr_nxt;
  logic [K-1:0]          we_nxt;
  logic [NCH*DATA_W-1:0] wdata_nxt;
  logic                  re_nxt, rlast_nxt, ram_read_last;

  logic              ld_clr, ld_inc, ld_last;
  logic [ADDR_W-1:0] ld_row, ld_col;
  logic              rd_clr, rd_inc, rd_cnt_last;
  logic [ADDR_W-1:0] rd_row, rd_col_unused;

  logic              pv    [RD_LAT];
  logic [ADDR_W-1:0] pidx  [RD_LAT];
  logic              plast [RD_LAT];

  kernel_idx_counter #(.ROWS(K), .COLS(K), .W(ADDR_W)) u_load_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (ld_clr),
    .inc  (ld_inc),
    .row  (ld_row),
    .col  (ld_col),
    .last (ld_last)
  );

  kernel_idx_counter #(.ROWS(K), .COLS(1), .W(ADDR_W)) u_read_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (rd_clr),
    .inc  (rd_inc),
    .row  (rd_row),
    .col  (rd_col_unused),
    .last (rd_cnt_last)
  );

  always_comb begin
    state_nxt     = state;
    w_ready_nxt   = w_ready;
    load_done_nxt = load_done;
    rd_busy_nxt   = rd_busy;
    cmd_err_nxt   = 1'b0;
    we_nxt        = '0;
    waddr_nxt     = ram_addr_write;
    wdata_nxt     = ram_data_in;
    re_nxt        = 1'b0;
    raddr_nxt     = ram_addr_read;
    rlast_nxt     = 1'b0;
    ld_clr        = 1'b0;
    ld_inc        = 1'b0;
    rd_clr        = 1'b0;
    rd_inc        = 1'b0;

    case (state)
      ST_IDLE: begin
        if (load_start) begin
          state_nxt   = ST_LOAD;
          w_ready_nxt = 1'b1;
          ld_clr      = 1'b1;
          rd_clr      = 1'b1;
        end
        if (rd_start) cmd_err_nxt = 1'b1;
      end

      ST_LOAD: begin
        // A beat arriving with load_start is dropped so the restart begins cleanly at beat 0.
        if (load_start) begin
          ld_clr = 1'b1;
        end else if (w_valid && w_ready) begin
          ld_inc    = 1'b1;
          we_nxt    = K'(1) << ld_col;
          waddr_nxt = ld_row;
          wdata_nxt = w_data;
          if (ld_last) begin
            w_ready_nxt   = 1'b0;
            load_done_nxt = 1'b1;
            state_nxt     = ST_LOADED;
          end
        end
        if (rd_start) cmd_err_nxt = 1'b1;
      end

      ST_LOADED: begin
        if (load_start) begin
          state_nxt     = ST_LOAD;
          w_ready_nxt   = 1'b1;
          load_done_nxt = 1'b0;
          ld_clr        = 1'b1;
          rd_clr        = 1'b1;
          if (rd_start) cmd_err_nxt = 1'b1;
        end else if (rd_start) begin
          state_nxt   = ST_READ;
          rd_busy_nxt = 1'b1;
          re_nxt      = 1'b1;
          raddr_nxt   = rd_row;
          rlast_nxt   = rd_cnt_last;
          rd_inc      = 1'b1;
        end
      end

      ST_READ: begin
        // Reads issue back to back until the one tagged last; the pipe then drains.
        if (ram_read_enable && !ram_read_last) begin
          re_nxt    = 1'b1;
          raddr_nxt = rd_row;
          rlast_nxt = rd_cnt_last;
          rd_inc    = 1'b1;
        end
        if (row_valid && rd_last) begin
          rd_busy_nxt = 1'b0;
          state_nxt   = ST_LOADED;
        end
        if (rd_start || load_start) cmd_err_nxt = 1'b1;
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      w_ready          <= 1'b0;
      load_done        <= 1'b0;
      rd_busy          <= 1'b0;
      cmd_err          <= 1'b0;
      ram_write_enable <= '0;
      ram_addr_write   <= '0;
      ram_data_in      <= '0;
      ram_read_enable  <= 1'b0;
      ram_addr_read    <= '0;
      ram_read_last    <= 1'b0;
    end else begin
      state            <= state_nxt;
      w_ready          <= w_ready_nxt;
      load_done        <= load_done_nxt;
      rd_busy          <= rd_busy_nxt;
      cmd_err          <= cmd_err_nxt;
      ram_write_enable <= we_nxt;
      ram_addr_write   <= waddr_nxt;
      ram_data_in      <= wdata_nxt;
      ram_read_enable  <= re_nxt;
      ram_addr_read    <= raddr_nxt;
      ram_read_last    <= rlast_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pv[i]    <= 1'b0;
        pidx[i]  <= '0;
        plast[i] <= 1'b0;
      end
    end else begin
      pv[0]    <= ram_read_enable;
      pidx[0]  <= ram_addr_read;
      plast[0] <= ram_read_enable && ram_read_last;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pv[i]    <= pv[i-1];
        pidx[i]  <= pidx[i-1];
        plast[i] <= plast[i-1];
      end
    end
  end

  assign row_valid = pv[RD_LAT-1];
  assign row_idx   = pidx[RD_LAT-1];
  assign rd_last   = plast[RD_LAT-1];

endmodule

// File: tb/tb_weight_ram_ctrl.sv
// Directed bench for weight_ram_ctrl; two instances (RD_LAT=1 and RD_LAT=3) share stimulus.
module tb_weight_ram_ctrl;
  import weight_ctrl_pkg::*;

  localparam int unsigned K  = K_DEF;
  localparam int unsigned AW = ADDR_W_DEF;
  localparam int unsigned DW = NCH_DEF * DATA_W_DEF;

  logic          clk, rst_n, load_start, w_valid, rd_start;
  logic [DW-1:0] w_data;

  logic          w_ready, load_done, rd_busy, row_valid, rd_last, cmd_err, ram_read_enable;
  logic [AW-1:0] row_idx, ram_addr_write, ram_addr_read;
  logic [K-1:0]  ram_write_enable;
  logic [DW-1:0] ram_data_in;

  logic          w_ready_3, load_done_3, rd_busy_3, row_valid_3, rd_last_3, cmd_err_3;
  logic          ram_read_enable_3;
  logic [AW-1:0] row_idx_3, ram_addr_write_3, ram_addr_read_3;
  logic [K-1:0]  ram_write_enable_3;
  logic [DW-1:0] ram_data_in_3;

  int unsigned errors = 0;
  int unsigned checks = 0;

  weight_ram_ctrl #(.RD_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .w_valid(w_valid), .w_ready(w_ready),
    .w_data(w_data), .load_done(load_done), .rd_start(rd_start), .rd_busy(rd_busy),
    .row_valid(row_valid), .row_idx(row_idx), .rd_last(rd_last), .cmd_err(cmd_err),
    .ram_addr_write(ram_addr_write), .ram_write_enable(ram_write_enable),
    .ram_data_in(ram_data_in), .ram_addr_read(ram_addr_read), .ram_read_enable(ram_read_enable)
  );

  weight_ram_ctrl #(.RD_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .w_valid(w_valid), .w_ready(w_ready_3),
    .w_data(w_data), .load_done(load_done_3), .rd_start(rd_start), .rd_busy(rd_busy_3),
    .row_valid(row_valid_3), .row_idx(row_idx_3), .rd_last(rd_last_3), .cmd_err(cmd_err_3),
    .ram_addr_write(ram_addr_write_3), .ram_write_enable(ram_write_enable_3),
    .ram_data_in(ram_data_in_3), .ram_addr_read(ram_addr_read_3),
    .ram_read_enable(ram_read_enable_3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] beat_data(input int unsigned n);
    logic [15:0] v;
    v = n[15:0];
    return {v, v, v};
  endfunction

  function automatic logic [K-1:0] onehot(input int unsigned c);
    logic [K-1:0] r;
    r = '0;
    r[c] = 1'b1;
    return r;
  endfunction

  initial begin
    int unsigned beat;
    int unsigned guard;

    rst_n = 1'b0; load_start = 1'b0; w_valid = 1'b0; rd_start = 1'b0; w_data = '0;
    repeat (3) tick();
    check("rst_w_ready", w_ready, 0);
    check("rst_load_done", load_done, 0);
    check("rst_we", ram_write_enable, 0);
    check("rst_re", ram_read_enable, 0);
    check("rst_row_valid", row_valid, 0);
    check("rst_busy", rd_busy, 0);
    check("rst_cmd_err", cmd_err, 0);
    rst_n = 1'b1;
    tick();

    // Reset asserted at beat 7 of a load
    load_start = 1'b1; tick(); load_start = 1'b0;
    check("ld_enter_ready", w_ready, 1);
    w_valid = 1'b1;
    for (int unsigned n = 0; n < 7; n++) begin
      w_data = beat_data(n + 1);
      tick();
    end
    check("pre_rst_we", ram_write_enable, onehot(1));
    rst_n = 1'b0;
    #1;
    check("midrst_w_ready", w_ready, 0);
    check("midrst_we", ram_write_enable, 0);
    check("midrst_addr_w", ram_addr_write, 0);
    check("midrst_data", ram_data_in, 0);
    check("midrst_load_done", load_done, 0);
    w_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("postrst_load_done", load_done, 0);
    check("postrst_w_ready", w_ready, 0);

    // rd_start in IDLE
    rd_start = 1'b1; tick(); rd_start = 1'b0;
    check("idle_rd_cmd_err", cmd_err, 1);
    check("idle_rd_no_re", ram_read_enable, 0);
    check("idle_rd_no_busy", rd_busy, 0);
    tick();
    check("idle_cmd_err_pulse", cmd_err, 0);
    check("idle_stays", w_ready, 0);

    // Full load with w_valid held high
    load_start = 1'b1; tick(); load_start = 1'b0;
    w_valid = 1'b1;
    for (int unsigned n = 0; n < K * K; n++) begin
      w_data = beat_data(n);
      tick();
      check("full_we", ram_write_enable, onehot(n % K));
      check("full_addr_w", ram_addr_write, n / K);
      check("full_data", ram_data_in, beat_data(n));
      check("full_load_done", load_done, n == K * K - 1);
      check("full_w_ready", w_ready, n != K * K - 1);
    end
    w_valid = 1'b0;
    tick();
    check("loaded_we_idle", ram_write_enable, 0);
    check("loaded_done", load_done, 1);

    // Row replay on both latencies
    rd_start = 1'b1; tick(); rd_start = 1'b0;
    for (int unsigned k = 0; k < 10; k++) begin
      check("rd_re", ram_read_enable, k < 5);
      check("rd_re_3", ram_read_enable_3, k < 5);
      if (k < 5) check("rd_addr", ram_addr_read, k);
      check("rd_rv1", row_valid, k >= 1 && k <= 5);
      if (k >= 1 && k <= 5) begin
        check("rd_idx1", row_idx, k - 1);
        check("rd_last1", rd_last, k == 5);
      end
      check("rd_busy1", rd_busy, k <= 5);
      check("rd_rv3", row_valid_3, k >= 3 && k <= 7);
      if (k >= 3 && k <= 7) begin
        check("rd_idx3", row_idx_3, k - 3);
        check("rd_last3", rd_last_3, k == 7);
      end
      check("rd_busy3", rd_busy_3, k <= 7);
      check("rd_load_done", load_done, 1);
      tick();
    end

    // load_start during READ is ignored with cmd_err
    rd_start = 1'b1; tick(); rd_start = 1'b0;
    check("rd2_re", ram_read_enable, 1);
    check("rd2_no_err", cmd_err, 0);
    load_start = 1'b1; tick(); load_start = 1'b0;
    check("rd_ls_cmd_err", cmd_err, 1);
    check("rd_ls_cmd_err3", cmd_err_3, 1);
    check("rd_ls_addr", ram_addr_read, 1);
    check("rd_ls_w_ready", w_ready, 0);
    tick();
    check("rd_ls_err_pulse", cmd_err, 0);
    check("rd_ls_addr2", ram_addr_read, 2);
    guard = 0;
    while ((rd_busy || rd_busy_3) && guard < 20) begin
      tick();
      guard++;
    end
    check("rd_drain_timeout", guard < 20, 1);
    check("rd_ls_load_done", load_done, 1);
    check("rd_ls_load_done3", load_done_3, 1);

    // LOADED -> LOAD, then backpressure
    load_start = 1'b1; tick(); load_start = 1'b0;
    check("reload_done_clr", load_done, 0);
    check("reload_ready", w_ready, 1);
    beat = 0;
    for (int unsigned i = 0; i < 10; i++) begin
      w_valid = (i % 2 == 0);
      w_data  = w_valid ? beat_data(100 + beat) : beat_data(16'hdead);
      tick();
      if (i % 2 == 0) begin
        check("bp_we", ram_write_enable, onehot(beat % K));
        check("bp_addr_w", ram_addr_write, beat / K);
        check("bp_data", ram_data_in, beat_data(100 + beat));
        beat++;
      end else begin
        check("bp_bubble_we", ram_write_enable, 0);
      end
    end
    w_valid = 1'b1;
    while (beat < 12) begin
      w_data = beat_data(100 + beat);
      tick();
      check("bp_we_run", ram_write_enable, onehot(beat % K));
      check("bp_addr_run", ram_addr_write, beat / K);
      beat++;
    end

    // Restart at beat 12: coincident beat dropped, counter back to 0
    load_start = 1'b1; w_data = beat_data(999); tick(); load_start = 1'b0;
    check("restart_no_we", ram_write_enable, 0);
    check("restart_no_err", cmd_err, 0);
    check("restart_ready", w_ready, 1);
    for (int unsigned n = 0; n < K * K; n++) begin
      w_data = beat_data(200 + n);
      tick();
      check("rs_we", ram_write_enable, onehot(n % K));
      check("rs_addr_w", ram_addr_write, n / K);
      check("rs_data", ram_data_in, beat_data(200 + n));
      check("rs_load_done", load_done, n == K * K - 1);
    end
    w_valid = 1'b0;
    tick();

    // Simultaneous load_start + rd_start in LOADED: load wins with cmd_err
    load_start = 1'b1; rd_start = 1'b1; tick(); load_start = 1'b0; rd_start = 1'b0;
    check("both_cmd_err", cmd_err, 1);
    check("both_w_ready", w_ready, 1);
    check("both_load_done", load_done, 0);
    check("both_no_re", ram_read_enable, 0);
    check("both_no_busy", rd_busy, 0);
    tick();
    check("both_err_pulse", cmd_err, 0);

    // rd_start inside LOAD
    rd_start = 1'b1; tick(); rd_start = 1'b0;
    check("load_rd_cmd_err", cmd_err, 1);
    check("load_rd_ready", w_ready, 1);
    check("load_rd_no_re", ram_read_enable, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
